// File: rtl/lfsr_rand_pkg.sv
// Shared types and helpers for the bounded LFSR random source.
// No timing or flow control of its own; consumed by lfsr_core and lfsr_rand_range.
package lfsr_rand_pkg;

  localparam int          LFSR_MAX_W = 64;
  localparam logic [31:0] TAPS_DEF   = 32'h0000_00AF;
  localparam logic [31:0] SEED_DEF   = 32'h0000_012C;

  typedef enum logic {
    IDLE   = 1'b0,
    REDUCE = 1'b1
  } state_t;

  // Galois step on the low 'width' bits; bits at or above 'width' come back zero.
  function automatic logic [LFSR_MAX_W-1:0] galois_next(
    input logic [LFSR_MAX_W-1:0] value,
    input logic [LFSR_MAX_W-1:0] taps,
    input int                    width
  );
    logic                  msb;
    logic [LFSR_MAX_W-1:0] nxt;
    msb = 1'b0;
    nxt = '0;
    for (int k = 0; k < LFSR_MAX_W; k++) begin
      if (k == width - 1) msb = value[k];
    end
    nxt[0] = taps[0] & msb;
    for (int k = 1; k < LFSR_MAX_W; k++) begin
      if (k < width) nxt[k] = value[k-1] ^ (taps[k] & msb);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Galois LFSR register with seed load (zero seed replaced by SEED) and enable.
// Latency: new value visible the cycle after en/seed_load; never stalls.
module lfsr_core
  import lfsr_rand_pkg::*;
#(
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(TAPS_DEF),
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(SEED_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] lfsr
);

  logic [LFSR_MAX_W-1:0] step_wide;
  logic [LFSR_W-1:0]     step;

  assign step_wide = galois_next(LFSR_MAX_W'(lfsr), LFSR_MAX_W'(TAPS), LFSR_W);
  assign step      = step_wide[LFSR_W-1:0];

  generate
    if (LFSR_W < LFSR_MAX_W) begin : g_hi
      logic unused_step_hi;
      assign unused_step_hi = ^step_wide[LFSR_MAX_W-1:LFSR_W];
    end
  endgenerate

  // A zero seed would lock the register at zero forever, so it is swapped for SEED.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
    end else if (seed_load) begin
      lfsr <= (seed == '0) ? SEED : seed;
    end else if (en) begin
      lfsr <= step;
    end
  end

endmodule

// File: rtl/lfsr_rand_range.sv
// Bounded random sample: LFSR snapshot reduced into [0, range-1] by repeated subtraction.
// Latency: floor(raw/range)+2 cycles from req; req ignored while busy, nothing queued.
module lfsr_rand_range
  import lfsr_rand_pkg::*;
#(
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(TAPS_DEF),
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(SEED_DEF),
  parameter int                OUT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              req,
  input  logic [OUT_W-1:0]  range,
  output logic [OUT_W-1:0]  rand_out,
  output logic              rand_valid,
  output logic              busy
);

  logic [LFSR_W-1:0] lfsr;
  state_t            state, state_nxt;
  logic [OUT_W-1:0]  work, work_nxt;
  logic [OUT_W-1:0]  rng, rng_nxt;
  logic [OUT_W-1:0]  out_nxt;
  logic              valid_nxt;
  logic              busy_nxt;

  lfsr_core #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .SEED   (SEED)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .seed_load (seed_load),
    .seed      (seed),
    .lfsr      (lfsr)
  );

  generate
    if (LFSR_W > OUT_W) begin : g_hi
      logic unused_lfsr_hi;
      assign unused_lfsr_hi = ^lfsr[LFSR_W-1:OUT_W];
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    rng_nxt   = rng;
    out_nxt   = rand_out;
    valid_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        // busy is still high in the rand_valid cycle, which blocks back-to-back accepts
        if (req && !busy) begin
          work_nxt  = lfsr[OUT_W-1:0];
          rng_nxt   = range;
          state_nxt = REDUCE;
        end
      end
      REDUCE: begin
        if ((rng != '0) && (work >= rng)) begin
          work_nxt = work - rng;
        end else begin
          out_nxt   = work;
          valid_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Covers accept cycle through the cycle that raises rand_valid.
  assign busy_nxt = (state == REDUCE) || (state_nxt == REDUCE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      work       <= '0;
      rng        <= '0;
      rand_out   <= '0;
      rand_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      work       <= work_nxt;
      rng        <= rng_nxt;
      rand_out   <= out_nxt;
      rand_valid <= valid_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_lfsr_rand_range.sv
// Scoreboard bench for lfsr_rand_range: expected samples queued at request, checked on rand_valid.
// A reference LFSR tracks the register from the same stimulus.
module tb_lfsr_rand_range;

  localparam logic [31:0] SEED_V = 32'h0000_012C;
  localparam logic [31:0] TAPS_V = 32'h0000_00AF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        seed_load = 1'b0;
  logic [31:0] seed = '0;
  logic        req = 1'b0;
  logic [6:0]  range = '0;
  logic [6:0]  rand_out;
  logic        rand_valid;
  logic        busy;

  lfsr_rand_range dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .seed_load  (seed_load),
    .seed       (seed),
    .req        (req),
    .range      (range),
    .rand_out   (rand_out),
    .rand_valid (rand_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] val;
    int         cyc;
  } exp_t;

  exp_t        sb[$];
  int          edges = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_lfsr = SEED_V;

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] v);
    return {v[30:0], 1'b0} ^ (v[31] ? TAPS_V : 32'h0);
  endfunction

  // Advance one edge, update the reference LFSR from the inputs present at that edge.
  task automatic tick();
    @(posedge clk);
    if (rst)            m_lfsr = SEED_V;
    else if (seed_load) m_lfsr = (seed == 0) ? SEED_V : seed;
    else if (en)        m_lfsr = m_step(m_lfsr);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Drive a request for one cycle and queue the expected result.
  task automatic request(input logic [6:0] rg);
    exp_t       e;
    logic [6:0] raw;
    int         k;
    raw   = m_lfsr[6:0];
    k     = (rg == 0) ? 0 : int'(raw) / int'(rg);
    e.val = (rg == 0) ? raw : 7'(int'(raw) % int'(rg));
    e.cyc = edges + k + 2;
    sb.push_back(e);
    req   = 1'b1;
    range = rg;
    tick();
    req   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(n < 400), 32'd1);
  endtask

  always @(negedge clk) begin
    if (rand_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rand_out", 32'(rand_out), 32'(e.val));
        check("valid_cycle", 32'(edges), 32'(e.cyc));
      end
    end else if (sb.size() != 0 && edges > sb[0].cyc) begin
      check("missing_valid", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
  end

  initial begin
    tick();
    do_reset();
    check("rst_lfsr", dut.u_core.lfsr, SEED_V);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(rand_valid), 32'd0);
    check("rst_out", 32'(rand_out), 32'd0);

    // Full range: raw low bits of 0x12C
    request(7'd0);
    check("t1_busy_t1", 32'(busy), 32'd1);
    check("t1_valid_t1", 32'(rand_valid), 32'd0);
    tick();
    check("t1_busy_t2", 32'(busy), 32'd1);
    check("t1_valid_t2", 32'(rand_valid), 32'd1);
    check("t1_out_44", 32'(rand_out), 32'd44);
    tick();
    check("t1_busy_t3", 32'(busy), 32'd0);
    wait_idle();

    // range 10 from raw 44, with a stray request while busy
    request(7'd10);
    tick();
    tick();
    req   = 1'b1;
    range = 7'd3;
    tick();
    req   = 1'b0;
    wait_idle();
    repeat (5) tick();
    check("t2_out_held", 32'(rand_out), 32'd4);

    // Single step from reset seed
    do_reset();
    en = 1'b1;
    tick();
    en = 1'b0;
    check("t3_lfsr", dut.u_core.lfsr, 32'h0000_0258);
    request(7'd0);
    wait_idle();

    // Msb set: taps folded in
    seed_load = 1'b1;
    seed      = 32'h8000_0000;
    tick();
    seed_load = 1'b0;
    check("t4_load", dut.u_core.lfsr, 32'h8000_0000);
    en = 1'b1;
    tick();
    en = 1'b0;
    check("t4_step", dut.u_core.lfsr, 32'h0000_00AF);

    // Load beats en, zero seed substituted
    seed_load = 1'b1;
    seed      = 32'h0;
    en        = 1'b1;
    tick();
    seed_load = 1'b0;
    en        = 1'b0;
    check("t5_zero_seed", dut.u_core.lfsr, SEED_V);

    // Worst case: range 1 from raw 127
    seed_load = 1'b1;
    seed      = 32'h0000_007F;
    tick();
    seed_load = 1'b0;
    request(7'd1);
    wait_idle();

    // Same request aborted by reset mid-reduction
    seed_load = 1'b1;
    seed      = 32'h0000_007F;
    tick();
    seed_load = 1'b0;
    req   = 1'b1;
    range = 7'd1;
    tick();
    req   = 1'b0;
    repeat (49) tick();
    check("t6_busy_mid", 32'(busy), 32'd1);
    do_reset();
    check("t6_abort_busy", 32'(busy), 32'd0);
    check("t6_abort_valid", 32'(rand_valid), 32'd0);
    check("t6_abort_lfsr", dut.u_core.lfsr, SEED_V);
    repeat (150) tick();

    // Random seeds, step counts, ranges, and en toggling while busy
    for (int i = 0; i < 8; i++) begin
      seed_load = 1'b1;
      seed      = $urandom;
      tick();
      seed_load = 1'b0;
      en = 1'b1;
      repeat ($urandom_range(0, 6)) tick();
      en = 1'($urandom_range(0, 1));
      request(7'($urandom_range(0, 127)));
      en = 1'($urandom_range(0, 1));
      wait_idle();
      en = 1'b0;
      check("rand_lfsr", dut.u_core.lfsr, m_lfsr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
